i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

Synthesisable, parametrised I2C target (slave) with an internal byte-wide register memory, replacing the behavioural-only target model used on the iCE40 sensor-management benches. SCL/SDA are oversampled on the system clock, START/STOP/repeated-START are detected, and a 1- or 2-byte register offset with auto-increment supports burst reads and writes. A local host port gives the fabric simultaneous access to the same memory.

## Interface
- SLAVE_ADDR, 7'h36, 7-bit target address
- OFS_BYTES, 2, register-offset bytes sent after address+W (1 or 2)
- MEM_DEPTH, 256, memory bytes (power of two, 2..65536)
- SYNC_STAGES, 2, synchroniser flops on SCL/SDA (>=2)

- clk  in  1  system clock, >= 10x SCL frequency
- rst_n  in  1  reset, asynchronous, active-low
- scl_i  in  1  SCL pin input
- sda_i  in  1  SDA pin input
- sda_oe  out  1  1 = pull SDA low, 0 = release (open drain)
- host_addr  in  log2(MEM_DEPTH)  host port address
- host_we  in  1  host write strobe
- host_wdata  in  8  host write data
- host_rdata  out  8  host read data, registered
- busy  out  1  high from addressed START to STOP
- wr_pulse  out  1  one-cycle pulse per I2C byte committed
- wr_addr  out  log2(MEM_DEPTH)  address of committed byte

## Operation
- Reset: sda_oe=0, busy=0, wr_pulse=0, wr_addr=0, host_rdata=0, offset=0, state IDLE; memory contents not reset.
- Conditions on synchronised signals: START = SDA fall while SCL high; STOP = SDA rise while SCL high. STOP in any state -> IDLE, sda_oe=0, busy=0. START (incl. repeated) in any state -> ADDR, bit count 0, offset kept.
- Data sampled on SCL rise; sda_oe changed only after SCL fall.
- States: IDLE, ADDR, ADDR_ACK, OFS, OFS_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
- ADDR: shift 8 bits MSB first. Match -> ADDR_ACK (sda_oe=1 for ACK bit), busy=1; mismatch -> WAIT_STOP, no drive.
- R/W=0: OFS receives OFS_BYTES bytes, each ACKed; offset = bytes MSB first, truncated mod MEM_DEPTH (1-byte mode: offset[15:8]=0). Then WR: each byte ACKed, written to mem[offset] at 8th SCL rise (+1 clk), wr_pulse/wr_addr asserted, offset+1 wrapping at MEM_DEPTH.
- R/W=1: after ADDR_ACK, mem[offset] loaded, bits driven MSB first (sda_oe = ~bit). RD_ACK samples master: ACK -> offset+1 (wrap), next byte; NACK -> WAIT_STOP, sda_oe=0.
- Host port: host_rdata = mem[host_addr] one cycle later. Same-cycle same-address write collision: I2C write wins, host write dropped.

## Timing
- Pin-to-internal latency: SYNC_STAGES clk; edge detect +1 clk.
- sda_oe update: registered in the clk after SCL-fall detection (SYNC_STAGES+1 clk after pin edge), well within SCL low time at >=10x ratio.
- Read byte fetched from memory in the cycle of the SCL fall ending the ACK bit; first data bit driven next clk.
- wr_pulse: exactly 1 clk, SYNC_STAGES+2 clk after the 8th data SCL rise.
- rst_n assertion mid-transfer releases SDA immediately (asynchronous); after release the block waits for START.

## Configuration
- I2C_TGT_GCALL_EN defined: general-call address 7'h00 with W is ACKed and handled exactly as an own-address write; 7'h00 with R is NACKed. Undefined: 7'h00 is never ACKed.

## Structure
- Package i2c_tgt_pkg: state enum, condition codes (NONE/START/STOP), ACK/NACK constants, helper for offset width.
- Sub-module i2c_tgt_cond_det: SCL/SDA synchronisers, SCL rise/fall pulses, START/STOP pulses. Top holds FSM, shifter, offset counter, memory.

## Test plan
- Write: START, 0x6C, 0x00, 0x10, 0xA5, 0x5A, STOP -> all 5 ACKed; mem[0x10]=0xA5, mem[0x11]=0x5A; two wr_pulses with wr_addr 0x10, 0x11.
- Random read: write offset 0x0010, repeated START, 0x6D, ACK, NACK -> bytes 0xA5, 0x5A returned; sda_oe=0 after NACK.
- Wrap: MEM_DEPTH=256, write 0xFF offset then 3 bytes 1,2,3 -> mem[0xFF]=1, mem[0x00]=2, mem[0x01]=3.
- Wrong address 0x70 -> NACK, no wr_pulse, busy=0, sda_oe stays 0 until STOP.
- rst_n low while target drives ACK -> sda_oe=0 same cycle; next valid transaction completes normally.
- I2C_TGT_GCALL_EN: 0x00+W with data 0x33 at offset 0x0004 -> ACKed, mem[4]=0x33; without macro -> NACK, memory unchanged.

Source files
------------

// File: rtl/i2c_tgt_pkg.sv
// Shared types for the I2C register target: FSM state codes, bus condition codes, ACK levels.
// No logic; no latency; no backpressure.
// Imported by i2c_tgt_cond_det and i2c_target_regs.
package i2c_tgt_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_OFS       = 4'd3;
    localparam logic [3:0] ST_OFS_ACK   = 4'd4;
    localparam logic [3:0] ST_WR        = 4'd5;
    localparam logic [3:0] ST_WR_ACK    = 4'd6;
    localparam logic [3:0] ST_RD        = 4'd7;
    localparam logic [3:0] ST_RD_ACK    = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP = 4'd9;

    typedef enum logic [1:0] {
        COND_NONE  = 2'd0,
        COND_START = 2'd1,
        COND_STOP  = 2'd2
    } cond_t;

    // SDA line levels as seen on the bus during the acknowledge bit
    localparam logic SDA_ACK  = 1'b0;
    localparam logic SDA_NACK = 1'b1;

    function automatic int ofs_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/i2c_tgt_cond_det.sv
// SCL/SDA synchroniser and bus event detector (SCL rise/fall, START, STOP).
// Latency: SYNC_STAGES clk to synchronised level, pulses valid in that same cycle (edge register +1).
// No backpressure: pulses are single-cycle and must be consumed when asserted.
module i2c_tgt_cond_det
    import i2c_tgt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  scl_i,
    input  logic  sda_i,
    output logic  scl_rise,
    output logic  scl_fall,
    output logic  sda_s,
    output cond_t cond
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Idle bus is high, so reset the chains high to avoid a false edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    always_comb begin
        cond = COND_NONE;
        if (scl_s && scl_d && sda_d && !sda_s) begin
            cond = COND_START;
        end else if (scl_s && scl_d && !sda_d && sda_s) begin
            cond = COND_STOP;
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with byte register memory, auto-incrementing offset and a host access port.
// Latency: sda_oe SYNC_STAGES+1 clk after SCL fall; wr_pulse SYNC_STAGES+2 clk after 8th data SCL rise; host_rdata 1 clk.
// No backpressure (I2C has no clock stretching here); I2C write beats a same-address host write. Option: I2C_TGT_GCALL_EN.
module i2c_target_regs
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h36,
    parameter int         OFS_BYTES   = 2,
    parameter int         MEM_DEPTH   = 256,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = ofs_width(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          busy,
    output logic          wr_pulse,
    output logic [AW-1:0] wr_addr
);

    logic          scl_rise;
    logic          scl_fall;
    logic          sda_s;
    cond_t         cond;

    logic [3:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    ofs_hi;
    logic [1:0]    ofs_cnt;
    logic [AW-1:0] offset;
    logic [AW-1:0] offset_inc;
    logic          rw;
    logic          mack;
    logic          wr_pend;
    logic [7:0]    rx_byte;
    logic          addr_match;
    logic [7:0]    mem [MEM_DEPTH];

    i2c_tgt_cond_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cond_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .cond     (cond)
    );

    assign rx_byte    = {shreg[6:0], sda_s};
    assign offset_inc = offset + AW'(1);

`ifdef I2C_TGT_GCALL_EN
    assign addr_match = (rx_byte[7:1] == SLAVE_ADDR) || (rx_byte == 8'h00);
`else
    assign addr_match = (rx_byte[7:1] == SLAVE_ADDR);
`endif

    // Bits are taken on SCL rise; SDA drive changes only on SCL fall. In the
    // *_ACK receive states the first fall asserts ACK and the second releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ofs_hi   <= '0;
            ofs_cnt  <= '0;
            offset   <= '0;
            rw       <= 1'b0;
            mack     <= 1'b0;
            wr_pend  <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
        end else begin
            wr_pend  <= 1'b0;
            wr_pulse <= wr_pend;
            if (wr_pend) begin
                wr_addr <= offset;
                offset  <= offset_inc;
            end

            if (cond == COND_STOP) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (cond == COND_START) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                ofs_cnt <= '0;
                ofs_hi  <= '0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (addr_match) begin
                                    state <= ST_ADDR_ACK;
                                    rw    <= sda_s;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (rw) begin
                                state   <= ST_RD;
                                shreg   <= mem[offset];
                                sda_oe  <= ~mem[offset][7];
                                bit_cnt <= '0;
                            end else begin
                                state  <= ST_OFS;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_OFS: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                state   <= ST_OFS_ACK;
                                ofs_hi  <= rx_byte;
                                ofs_cnt <= ofs_cnt + 2'd1;
                                if (ofs_cnt == 2'(OFS_BYTES - 1)) begin
                                    offset <= AW'((OFS_BYTES == 1) ? {8'h00, rx_byte}
                                                                   : {ofs_hi, rx_byte});
                                end
                            end
                        end
                    end
                    ST_OFS_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (ofs_cnt == 2'(OFS_BYTES)) ? ST_WR : ST_OFS;
                            end
                        end
                    end
                    ST_WR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                wr_pend <= 1'b1;
                                state   <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_WR;
                            end
                        end
                    end
                    ST_RD: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state  <= ST_RD_ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            mack <= (sda_s == SDA_ACK);
                        end
                        if (scl_fall) begin
                            if (mack) begin
                                offset  <= offset_inc;
                                shreg   <= mem[offset_inc];
                                sda_oe  <= ~mem[offset_inc][7];
                                bit_cnt <= '0;
                                state   <= ST_RD;
                            end else begin
                                state  <= ST_WAIT_STOP;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Register array is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_pend) begin
            mem[offset] <= shreg;
        end
        if (host_we && !(wr_pend && (host_addr == offset))) begin
            mem[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata <= '0;
        end else begin
            host_rdata <= mem[host_addr];
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed + randomized bench for i2c_target_regs with a bus-level master and a flat memory model.
module tb_i2c_target_regs;

    localparam int         Q   = 5;
    localparam logic [6:0] SLV = 7'h36;
`ifdef I2C_TGT_GCALL_EN
    localparam logic       GC  = 1'b1;
`else
    localparam logic       GC  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] host_addr = 8'h00;
    logic       host_we = 1'b0;
    logic [7:0] host_wdata = 8'h00;
    logic [7:0] host_rdata;
    logic       busy;
    logic       wr_pulse;
    logic [7:0] wr_addr;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_mem [256];
    logic [7:0] wdat [16];
    logic [7:0] wp_q [$];
    logic       pulse_prev = 1'b0;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_oe     (sda_oe),
        .host_addr  (host_addr),
        .host_we    (host_we),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .busy       (busy),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr)
    );

    always @(negedge clk) begin
        if (rst_n && wr_pulse) begin
            wp_q.push_back(wr_addr);
            total++;
            assert (pulse_prev === 1'b0) else begin
                bad++;
                $error("FAIL wr_pulse_width observed=2+ cycles expected=1 cycle");
            end
        end
        pulse_prev <= wr_pulse;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_c();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
        qwait();
    endtask

    task automatic tx_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; qwait();
            scl_m = 1'b1; qwait(); qwait();
            scl_m = 1'b0; qwait();
        end
        sda_m = 1'b1;
    endtask

    task automatic ack_bit(output logic ack);
        qwait();
        scl_m = 1'b1; qwait();
        ack = ~sda_i; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic rx_byte(input logic mack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            qwait();
            scl_m = 1'b1; qwait();
            b[i] = sda_i; qwait();
            scl_m = 1'b0; qwait();
        end
        sda_m = ~mack; qwait();
        scl_m = 1'b1; qwait(); qwait();
        scl_m = 1'b0; qwait();
        sda_m = 1'b1;
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic host_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        host_addr = a;
        @(negedge clk);
        chk8(tag, host_rdata, exp);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [15:0] ofs, input int n,
                            input logic exp_ack);
        logic ack;
        logic [7:0] idx;
        wp_q.delete();
        start_c();
        tx_bits({a, 1'b0}); ack_bit(ack);
        chk1("wr_addr_ack", ack, exp_ack);
        if (exp_ack) begin
            chk1("busy_in_xfer", busy, 1'b1);
            tx_bits(ofs[15:8]); ack_bit(ack); chk1("ofs_hi_ack", ack, 1'b1);
            tx_bits(ofs[7:0]);  ack_bit(ack); chk1("ofs_lo_ack", ack, 1'b1);
            for (int i = 0; i < n; i++) begin
                tx_bits(wdat[i]); ack_bit(ack);
                chk1("data_ack", ack, 1'b1);
                idx = 8'(ofs + 16'(i));
                exp_mem[idx] = wdat[i];
            end
        end else begin
            chk1("busy_unaddressed", busy, 1'b0);
            tx_bits(wdat[0]); ack_bit(ack);
            chk1("data_after_nack", ack, 1'b0);
            chk1("sda_idle_before_stop", sda_oe, 1'b0);
        end
        stop_c();
        chk1("busy_after_stop", busy, 1'b0);
        chk8("wr_pulse_count", 8'(wp_q.size()), exp_ack ? 8'(n) : 8'd0);
        if (exp_ack) begin
            for (int i = 0; i < n && i < wp_q.size(); i++) begin
                chk8("wr_addr_seq", wp_q[i], 8'(ofs + 16'(i)));
            end
        end
    endtask

    task automatic do_read(input logic [15:0] ofs, input int n);
        logic ack;
        logic [7:0] b;
        start_c();
        tx_bits({SLV, 1'b0}); ack_bit(ack); chk1("rd_addrw_ack", ack, 1'b1);
        tx_bits(ofs[15:8]);   ack_bit(ack); chk1("rd_ofs_hi_ack", ack, 1'b1);
        tx_bits(ofs[7:0]);    ack_bit(ack); chk1("rd_ofs_lo_ack", ack, 1'b1);
        start_c();
        tx_bits({SLV, 1'b1}); ack_bit(ack); chk1("rd_addrr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            rx_byte(i != n - 1, b);
            chk8("rd_data", b, exp_mem[8'(ofs + 16'(i))]);
        end
        chk1("rd_release_after_nack", sda_oe, 1'b0);
        stop_c();
        chk1("rd_busy_after_stop", busy, 1'b0);
    endtask

    initial begin
        logic ack;
        logic [15:0] rofs;
        int n;

        repeat (3) @(negedge clk);
        chk1("rst_sda_oe", sda_oe, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_wr_pulse", wr_pulse, 1'b0);
        chk8("rst_wr_addr", wr_addr, 8'h00);
        chk8("rst_host_rdata", host_rdata, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 256; i++) begin
            host_wr(8'(i), 8'($urandom));
        end

        // Basic burst write, then readback via both ports
        wdat[0] = 8'hA5; wdat[1] = 8'h5A;
        do_write(SLV, 16'h0010, 2, 1'b1);
        host_chk("t1_mem10", 8'h10, 8'hA5);
        host_chk("t1_mem11", 8'h11, 8'h5A);
        do_read(16'h0010, 2);

        // Offset wrap at the top of memory
        wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h03;
        do_write(SLV, 16'h00FF, 3, 1'b1);
        host_chk("wrap_ff", 8'hFF, 8'h01);
        host_chk("wrap_00", 8'h00, 8'h02);
        host_chk("wrap_01", 8'h01, 8'h03);
        do_read(16'h00FE, 4);

        // Foreign address is ignored
        wdat[0] = 8'hC3;
        do_write(7'h70, 16'h0000, 1, 1'b0);

        // General call write and general call read
        wdat[0] = 8'h33;
        do_write(7'h00, 16'h0004, 1, GC);
        host_chk("gcall_mem4", 8'h04, exp_mem[4]);
        start_c();
        tx_bits(8'h01); ack_bit(ack);
        chk1("gcall_read_nack", ack, 1'b0);
        stop_c();

        // Reset while the target is holding ACK
        start_c();
        tx_bits({SLV, 1'b0});
        chk1("ack_driven", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_async_release", sda_oe, 1'b0);
        chk1("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        scl_m = 1'b1; sda_m = 1'b1;
        qwait(); qwait();
        wdat[0] = 8'h9E;
        do_write(SLV, 16'h0040, 1, 1'b1);
        host_chk("post_rst_mem40", 8'h40, 8'h9E);

        // Randomized bursts with high offset byte discarded by truncation
        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
            rofs = 16'($urandom);
            do_write(SLV, rofs, n, 1'b1);
            host_wr(8'($urandom), 8'($urandom));
            do_read({8'($urandom), rofs[7:0] - 8'd1}, $urandom_range(1, 5));
        end

        for (int i = 0; i < 256; i++) begin
            host_chk("final_sweep", 8'(i), exp_mem[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
